// File: rtl/n_bit_divider_pkg.sv
// Shared types and helpers for the restoring divider.
// Contents:
//   div_state_e : divider FSM states
//   cnt_width() : width of the step counter for a given operand width
package n_bit_divider_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } div_state_e;

    // Evaluates to $clog2(bit_num). The counter must hold values 0 .. bit_num-1.
    // The result is floored at 1 so the counter is never zero-width.
    function automatic int unsigned cnt_width(input int unsigned bit_num);
        return (bit_num < 2) ? 1 : $clog2(bit_num);
    endfunction

endpackage

// File: rtl/n_bit_ripple_carry_adder.sv
// Ripple-carry adder/subtractor.
// Ports:
//   op1_i   : first operand
//   op2_i   : second operand
//   sgn_op2 : 1 = subtract op2_i (two's complement: invert and carry in 1)
//   sum_o   : op1_i +/- op2_i, truncated to BIT_NUM bits
//   carry_o : carry out of the MSB; when subtracting, 1 means no borrow (op1 >= op2)
module n_bit_ripple_carry_adder #(
    parameter int unsigned BIT_NUM = 8
) (
    input  logic [BIT_NUM-1:0] op1_i,
    input  logic [BIT_NUM-1:0] op2_i,
    input  logic               sgn_op2,
    output logic [BIT_NUM-1:0] sum_o,
    output logic               carry_o
);

    logic [BIT_NUM-1:0] op2_eff;
    logic [BIT_NUM:0]   carry;

    assign op2_eff  = op2_i ^ {BIT_NUM{sgn_op2}};
    assign carry[0] = sgn_op2;

    for (genvar i = 0; i < BIT_NUM; i++) begin : g_fa
        assign sum_o[i]     = op1_i[i] ^ op2_eff[i] ^ carry[i];
        assign carry[i + 1] = (op1_i[i] & op2_eff[i]) | ((op1_i[i] ^ op2_eff[i]) & carry[i]);
    end

    assign carry_o = carry[BIT_NUM];

endmodule

// File: rtl/n_bit_restoring_divider.sv
// Multi-cycle unsigned restoring divider, one quotient bit per cycle.
// Ports:
//   clk_i, arst_ni            : clock, asynchronous active-low reset
//   dividend_i, divisor_i     : operands, sampled on in_valid_i && in_ready_o
//   in_valid_i / in_ready_o   : request handshake (ready only when idle)
//   quotient_o, remainder_o   : result; held stable while out_valid_o && !out_ready_i
//   div_by_zero_o             : result came from a zero divisor (q = all ones, r = dividend)
//   out_valid_o / out_ready_i : result handshake
module n_bit_restoring_divider
    import n_bit_divider_pkg::*;
#(
    parameter int unsigned BIT_NUM = 8
) (
    input  logic               clk_i,
    input  logic               arst_ni,
    input  logic [BIT_NUM-1:0] dividend_i,
    input  logic [BIT_NUM-1:0] divisor_i,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    output logic [BIT_NUM-1:0] quotient_o,
    output logic [BIT_NUM-1:0] remainder_o,
    output logic               div_by_zero_o,
    output logic               out_valid_o,
    input  logic               out_ready_i
);

    localparam int unsigned CNT_W = cnt_width(BIT_NUM);

    div_state_e         state_q, state_d;
    logic [BIT_NUM-1:0] q_q, q_d;        // quotient shift register, dividend shifts out of MSB
    logic [BIT_NUM:0]   r_q, r_d;        // partial remainder
    logic [BIT_NUM-1:0] div_q, div_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               dbz_q, dbz_d;

    logic [BIT_NUM:0]   shifted;         // S = {R, next dividend bit}
    logic [BIT_NUM:0]   diff;            // T = S - divisor
    logic               no_borrow;

    assign shifted = {r_q[BIT_NUM-1:0], q_q[BIT_NUM-1]};

    n_bit_ripple_carry_adder #(
        .BIT_NUM (BIT_NUM + 1)
    ) u_sub (
        .op1_i   (shifted),
        .op2_i   ({1'b0, div_q}),
        .sgn_op2 (1'b1),
        .sum_o   (diff),
        .carry_o (no_borrow)
    );

    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        r_d     = r_q;
        div_d   = div_q;
        cnt_d   = cnt_q;
        dbz_d   = dbz_q;

        case (state_q)
            IDLE: begin
                if (in_valid_i) begin
                    div_d = divisor_i;
                    if (divisor_i == '0) begin
                        q_d     = '1;
                        r_d     = {1'b0, dividend_i};
                        dbz_d   = 1'b1;
                        cnt_d   = '0;
                        state_d = DONE;
                    end else begin
                        q_d     = dividend_i;
                        r_d     = '0;
                        dbz_d   = 1'b0;
                        cnt_d   = CNT_W'(BIT_NUM - 1);
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                r_d = no_borrow ? diff : shifted;
                q_d = {q_q[BIT_NUM-2:0], no_borrow};
                if (cnt_q == '0) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DONE: begin
                if (out_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            q_q   <= '0;
            r_q   <= '0;
            div_q <= '0;
            cnt_q <= '0;
            dbz_q <= 1'b0;
        end else begin
            q_q   <= q_d;
            r_q   <= r_d;
            div_q <= div_d;
            cnt_q <= cnt_d;
            dbz_q <= dbz_d;
        end
    end

    assign in_ready_o    = (state_q == IDLE);
    assign out_valid_o   = (state_q == DONE);
    assign quotient_o    = q_q;
    assign remainder_o   = r_q[BIT_NUM-1:0];
    assign div_by_zero_o = dbz_q;

    // A finished remainder is always below the divisor, so the extra R bit must be clear.
    r_msb_clear_in_done : assert property (
        @(posedge clk_i) disable iff (!arst_ni) (state_q == DONE) |-> !r_q[BIT_NUM]
    );

endmodule
